// File: rtl/alu_reservation_station.sv
// alu_reservation_station: buffers dispatched ALU/branch ops, wakes operands from the CDB, issues one ready op per cycle
module alu_reservation_station #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     dispatch_valid,
    output logic                     dispatch_ready,
    input  logic [10:0]              disp_control_signals,
    input  logic [2:0]               disp_branch_sel,
    input  logic [DATA_WIDTH-1:0]    disp_pc,
    input  logic [DATA_WIDTH-1:0]    disp_pc_value_at_prediction,
    input  logic                     disp_branch_prediction,
    input  logic [TAG_WIDTH-1:0]     disp_tag,
    input  logic                     disp_a_valid,
    input  logic                     disp_b_valid,
    input  logic [DATA_WIDTH-1:0]    disp_a_data,
    input  logic [DATA_WIDTH-1:0]    disp_b_data,
    input  logic [TAG_WIDTH-1:0]     disp_a_tag,
    input  logic [TAG_WIDTH-1:0]     disp_b_tag,
    input  logic                     cdb0_valid,
    input  logic [TAG_WIDTH-1:0]     cdb0_tag,
    input  logic [DATA_WIDTH-1:0]    cdb0_data,
    input  logic                     cdb1_valid,
    input  logic [TAG_WIDTH-1:0]     cdb1_tag,
    input  logic [DATA_WIDTH-1:0]    cdb1_data,
    input  logic                     cdb2_valid,
    input  logic [TAG_WIDTH-1:0]     cdb2_tag,
    input  logic [DATA_WIDTH-1:0]    cdb2_data,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic [10:0]              control_signals,
    output logic [2:0]               branch_sel,
    output logic [DATA_WIDTH-1:0]    pc,
    output logic [DATA_WIDTH-1:0]    pc_value_at_prediction,
    output logic                     branch_prediction,
    output logic [DATA_WIDTH-1:0]    data_a,
    output logic [DATA_WIDTH-1:0]    data_b,
    output logic [TAG_WIDTH-1:0]     issue_tag,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int IW = $clog2(DEPTH);
    localparam int OW = IW + 1;

    typedef struct packed {
        logic [10:0]           ctrl;
        logic [2:0]            bsel;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] ppc;
        logic                  pred;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  av;
        logic [DATA_WIDTH-1:0] ad;
        logic [TAG_WIDTH-1:0]  at;
        logic                  bv;
        logic [DATA_WIDTH-1:0] bd;
        logic [TAG_WIDTH-1:0]  bt;
    } ent_t;

    typedef struct packed {
        logic [10:0]           ctrl;
        logic [2:0]            bsel;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] ppc;
        logic                  pred;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } iss_t;

    logic [DEPTH-1:0]       valid_q, valid_d, rdy;
    ent_t                   ent_q [DEPTH];
    ent_t                   ent_d [DEPTH];
    ent_t                   disp_e;
    iss_t                   iss_q, iss_d;
    logic                   issue_valid_q, issue_valid_d;
    logic [IW-1:0]          sel, fre;
    logic                   any_rdy, accept, load;
    logic [2:0]             cv;
    logic [3*TAG_WIDTH-1:0] ct;
    logic [3*DATA_WIDTH-1:0] cd;
    logic [DATA_WIDTH:0]    da, db;
    logic [DATA_WIDTH:0]    wa [DEPTH];
    logic [DATA_WIDTH:0]    wb [DEPTH];

    // returns {hit, data}; scanning downward lets cdb0 override cdb1 and cdb2
    function automatic logic [DATA_WIDTH:0] snoop(
        input logic [TAG_WIDTH-1:0]    t,
        input logic [2:0]              v,
        input logic [3*TAG_WIDTH-1:0]  ts,
        input logic [3*DATA_WIDTH-1:0] ds
    );
        snoop = '0;
        for (int k = 2; k >= 0; k--)
            if (v[k] && ts[k*TAG_WIDTH +: TAG_WIDTH] == t)
                snoop = {1'b1, ds[k*DATA_WIDTH +: DATA_WIDTH]};
    endfunction

    assign cv = {cdb2_valid, cdb1_valid, cdb0_valid};
    assign ct = {cdb2_tag, cdb1_tag, cdb0_tag};
    assign cd = {cdb2_data, cdb1_data, cdb0_data};

    assign da = snoop(disp_a_tag, cv, ct, cd);
    assign db = snoop(disp_b_tag, cv, ct, cd);

    assign disp_e = '{
        ctrl: disp_control_signals,
        bsel: disp_branch_sel,
        pc:   disp_pc,
        ppc:  disp_pc_value_at_prediction,
        pred: disp_branch_prediction,
        tag:  disp_tag,
        av:   disp_a_valid | da[DATA_WIDTH],
        ad:   disp_a_valid ? disp_a_data : da[DATA_WIDTH-1:0],
        at:   disp_a_tag,
        bv:   disp_b_valid | db[DATA_WIDTH],
        bd:   disp_b_valid ? disp_b_data : db[DATA_WIDTH-1:0],
        bt:   disp_b_tag
    };

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign rdy[i] = valid_q[i] & ent_q[i].av & ent_q[i].bv;
        assign wa[i]  = snoop(ent_q[i].at, cv, ct, cd);
        assign wb[i]  = snoop(ent_q[i].bt, cv, ct, cd);
    end

    // lowest-index ready entry for issue and lowest-index free entry for dispatch
    always_comb begin
        sel = '0;
        fre = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (rdy[k]) sel = IW'(k);
            if (!valid_q[k]) fre = IW'(k);
        end
    end

    assign any_rdy        = |rdy;
    assign dispatch_ready = ~&valid_q;
    assign accept         = dispatch_valid & dispatch_ready & ~flush;
    assign load           = any_rdy & (~issue_valid_q | issue_ready) & ~flush;

    // entry next state: CDB wakeup, free on issue, fill on dispatch, flush kills all
    always_comb begin
        valid_d = valid_q;
        ent_d   = ent_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_q[k] && !ent_q[k].av && wa[k][DATA_WIDTH]) begin
                ent_d[k].av = 1'b1;
                ent_d[k].ad = wa[k][DATA_WIDTH-1:0];
            end
            if (valid_q[k] && !ent_q[k].bv && wb[k][DATA_WIDTH]) begin
                ent_d[k].bv = 1'b1;
                ent_d[k].bd = wb[k][DATA_WIDTH-1:0];
            end
        end
        if (load) valid_d[sel] = 1'b0;
        if (accept) begin
            valid_d[fre] = 1'b1;
            ent_d[fre]   = disp_e;
        end
        if (flush) valid_d = '0;
    end

    // entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) ent_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            ent_q   <= ent_d;
        end
    end

    // issue register next state: load when empty or draining, otherwise hold
    always_comb begin
        issue_valid_d = load | (issue_valid_q & ~issue_ready & ~flush);
        iss_d = load ? '{
            ctrl: ent_q[sel].ctrl,
            bsel: ent_q[sel].bsel,
            pc:   ent_q[sel].pc,
            ppc:  ent_q[sel].ppc,
            pred: ent_q[sel].pred,
            tag:  ent_q[sel].tag,
            a:    ent_q[sel].ad,
            b:    ent_q[sel].bd
        } : iss_q;
    end

    // issue register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid_q <= 1'b0;
            iss_q         <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            iss_q         <= iss_d;
        end
    end

    assign issue_valid            = issue_valid_q;
    assign control_signals        = iss_q.ctrl;
    assign branch_sel             = iss_q.bsel;
    assign pc                     = iss_q.pc;
    assign pc_value_at_prediction = iss_q.ppc;
    assign branch_prediction      = iss_q.pred;
    assign data_a                 = iss_q.a;
    assign data_b                 = iss_q.b;
    assign issue_tag              = iss_q.tag;

    // occupancy counts buffered entries only
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) occupancy = occupancy + OW'(valid_q[k]);
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// tb_alu_reservation_station: directed vectors, corner sequences and a randomized run against a reference model
module tb_alu_reservation_station;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int TW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, flush, dispatch_valid, dispatch_ready;
    logic [10:0] disp_control_signals;
    logic [2:0] disp_branch_sel;
    logic [DW-1:0] disp_pc, disp_pc_value_at_prediction;
    logic disp_branch_prediction;
    logic [TW-1:0] disp_tag, disp_a_tag, disp_b_tag;
    logic disp_a_valid, disp_b_valid;
    logic [DW-1:0] disp_a_data, disp_b_data;
    logic cdb0_valid, cdb1_valid, cdb2_valid;
    logic [TW-1:0] cdb0_tag, cdb1_tag, cdb2_tag;
    logic [DW-1:0] cdb0_data, cdb1_data, cdb2_data;
    logic issue_valid, issue_ready;
    logic [10:0] control_signals;
    logic [2:0] branch_sel;
    logic [DW-1:0] pc, pc_value_at_prediction, data_a, data_b;
    logic branch_prediction;
    logic [TW-1:0] issue_tag;
    logic [$clog2(DEPTH):0] occupancy;

    int checks = 0;
    int errors = 0;

    alu_reservation_station #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .disp_control_signals(disp_control_signals), .disp_branch_sel(disp_branch_sel),
        .disp_pc(disp_pc), .disp_pc_value_at_prediction(disp_pc_value_at_prediction),
        .disp_branch_prediction(disp_branch_prediction), .disp_tag(disp_tag),
        .disp_a_valid(disp_a_valid), .disp_b_valid(disp_b_valid),
        .disp_a_data(disp_a_data), .disp_b_data(disp_b_data),
        .disp_a_tag(disp_a_tag), .disp_b_tag(disp_b_tag),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .cdb2_valid(cdb2_valid), .cdb2_tag(cdb2_tag), .cdb2_data(cdb2_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .control_signals(control_signals), .branch_sel(branch_sel), .pc(pc),
        .pc_value_at_prediction(pc_value_at_prediction), .branch_prediction(branch_prediction),
        .data_a(data_a), .data_b(data_b), .issue_tag(issue_tag), .occupancy(occupancy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; dispatch_valid = 0;
        disp_control_signals = 0; disp_branch_sel = 0; disp_pc = 0; disp_pc_value_at_prediction = 0;
        disp_branch_prediction = 0; disp_tag = 0; disp_a_valid = 0; disp_b_valid = 0;
        disp_a_data = 0; disp_b_data = 0; disp_a_tag = 0; disp_b_tag = 0;
        cdb0_valid = 0; cdb0_tag = 0; cdb0_data = 0;
        cdb1_valid = 0; cdb1_tag = 0; cdb1_data = 0;
        cdb2_valid = 0; cdb2_tag = 0; cdb2_data = 0;
    endtask

    task automatic do_reset();
        idle();
        issue_ready = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic set_disp(input logic [TW-1:0] t, input logic av, input logic [DW-1:0] a, input logic [TW-1:0] at,
                            input logic bv, input logic [DW-1:0] b, input logic [TW-1:0] bt);
        idle();
        dispatch_valid = 1;
        disp_tag = t; disp_a_valid = av; disp_a_data = a; disp_a_tag = at;
        disp_b_valid = bv; disp_b_data = b; disp_b_tag = bt;
        disp_control_signals = 11'h5A5; disp_branch_sel = 3'd3;
        disp_pc = 32'h1000 + DW'(t); disp_pc_value_at_prediction = 32'h2000; disp_branch_prediction = 1;
    endtask

    task automatic set_cdb(input int p, input logic [TW-1:0] t, input logic [DW-1:0] d);
        if (p == 0) begin cdb0_valid = 1; cdb0_tag = t; cdb0_data = d; end
        if (p == 1) begin cdb1_valid = 1; cdb1_tag = t; cdb1_data = d; end
        if (p == 2) begin cdb2_valid = 1; cdb2_tag = t; cdb2_data = d; end
    endtask

    typedef struct {
        logic [TW-1:0] tag;
        logic av; logic [DW-1:0] a; logic [TW-1:0] at;
        logic bv; logic [DW-1:0] b; logic [TW-1:0] bt;
        int wp; int wd; logic dup; logic [TW-1:0] wt; logic [DW-1:0] wdat;
        int exp_k; logic [DW-1:0] ea; logic [DW-1:0] eb;
    } vec_t;

    vec_t vecs [7];

    typedef struct {
        logic [10:0] ctrl; logic [2:0] bsel; logic [DW-1:0] pc, ppc; logic pred; logic [TW-1:0] tag;
        bit av; logic [DW-1:0] ad; logic [TW-1:0] at;
        bit bv; logic [DW-1:0] bd; logic [TW-1:0] bt;
    } op_t;

    op_t m_e [DEPTH];
    bit  m_v [DEPTH];
    bit  m_iv;
    op_t m_is;

    function automatic bit cdb_hit(input logic [TW-1:0] t, output logic [DW-1:0] d);
        d = '0;
        if (cdb0_valid && cdb0_tag == t) begin d = cdb0_data; return 1; end
        if (cdb1_valid && cdb1_tag == t) begin d = cdb1_data; return 1; end
        if (cdb2_valid && cdb2_tag == t) begin d = cdb2_data; return 1; end
        return 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
        m_iv = 0;
    endtask

    // one clock edge of the reservation station, seen as a list of slots and a one-deep output latch
    task automatic model_step();
        int s, f;
        logic [DW-1:0] d;
        op_t n;
        s = -1; f = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (s < 0 && m_v[i] && m_e[i].av && m_e[i].bv) s = i;
            if (f < 0 && !m_v[i]) f = i;
        end
        if (flush) begin
            model_clear();
            return;
        end
        if (s >= 0 && (!m_iv || issue_ready)) begin
            m_iv = 1; m_is = m_e[s]; m_v[s] = 0;
        end else if (issue_ready) m_iv = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_v[i] && !m_e[i].av && cdb_hit(m_e[i].at, d)) begin m_e[i].av = 1; m_e[i].ad = d; end
            if (m_v[i] && !m_e[i].bv && cdb_hit(m_e[i].bt, d)) begin m_e[i].bv = 1; m_e[i].bd = d; end
        end
        if (dispatch_valid && f >= 0) begin
            n.ctrl = disp_control_signals; n.bsel = disp_branch_sel; n.pc = disp_pc;
            n.ppc = disp_pc_value_at_prediction; n.pred = disp_branch_prediction; n.tag = disp_tag;
            n.at = disp_a_tag; n.bt = disp_b_tag;
            n.av = disp_a_valid; n.ad = disp_a_data;
            if (!n.av && cdb_hit(disp_a_tag, d)) begin n.av = 1; n.ad = d; end
            n.bv = disp_b_valid; n.bd = disp_b_data;
            if (!n.bv && cdb_hit(disp_b_tag, d)) begin n.bv = 1; n.bd = d; end
            m_e[f] = n; m_v[f] = 1;
        end
    endtask

    initial begin
        int got;
        int occ;
        bit frf;
        logic [DW-1:0] ga, gb;
        logic [TW-1:0] gt;

        vecs[0] = '{tag:5,  av:1, a:'h10,   at:0,  bv:1, b:'h20, bt:0,  wp:-1, wd:0, dup:0, wt:0,  wdat:0,       exp_k:1, ea:'h10,   eb:'h20};
        vecs[1] = '{tag:6,  av:0, a:0,      at:9,  bv:1, b:'h20, bt:0,  wp:1,  wd:3, dup:0, wt:9,  wdat:'hDEAD,  exp_k:4, ea:'hDEAD, eb:'h20};
        vecs[2] = '{tag:6,  av:0, a:0,      at:9,  bv:1, b:'h20, bt:0,  wp:1,  wd:0, dup:0, wt:9,  wdat:'hDEAD,  exp_k:1, ea:'hDEAD, eb:'h20};
        vecs[3] = '{tag:7,  av:1, a:'h1234, at:0,  bv:0, b:0,     bt:12, wp:2,  wd:1, dup:0, wt:12, wdat:'hBEEF,  exp_k:2, ea:'h1234, eb:'hBEEF};
        vecs[4] = '{tag:8,  av:0, a:0,      at:3,  bv:1, b:5,     bt:0,  wp:0,  wd:2, dup:1, wt:3,  wdat:'hAAAA,  exp_k:3, ea:'hAAAA, eb:5};
        vecs[5] = '{tag:10, av:0, a:0,      at:4,  bv:0, b:0,     bt:4,  wp:2,  wd:1, dup:0, wt:4,  wdat:'h77,    exp_k:2, ea:'h77,   eb:'h77};
        vecs[6] = '{tag:11, av:0, a:0,      at:13, bv:1, b:1,     bt:0,  wp:0,  wd:0, dup:1, wt:13, wdat:'h1111,  exp_k:1, ea:'h1111, eb:1};

        do_reset();
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_dispatch_ready", dispatch_ready, 1);
        chk("rst_payload", {issue_tag, data_a, data_b}, 0);

        foreach (vecs[v]) begin
            do_reset();
            issue_ready = 1;
            got = -1; ga = 0; gb = 0; gt = 0;
            for (int k = 0; k < 7; k++) begin
                idle();
                if (k == 0) set_disp(vecs[v].tag, vecs[v].av, vecs[v].a, vecs[v].at, vecs[v].bv, vecs[v].b, vecs[v].bt);
                if (vecs[v].wp >= 0 && k == vecs[v].wd) begin
                    set_cdb(vecs[v].wp, vecs[v].wt, vecs[v].wdat);
                    if (vecs[v].dup) set_cdb(2, vecs[v].wt, ~vecs[v].wdat);
                end
                tick();
                if (issue_valid && got < 0) begin got = k; ga = data_a; gb = data_b; gt = issue_tag; end
            end
            idle();
            chk($sformatf("vec%0d_latency", v), 64'(got), 64'(vecs[v].exp_k));
            chk($sformatf("vec%0d_data_a", v), ga, vecs[v].ea);
            chk($sformatf("vec%0d_data_b", v), gb, vecs[v].eb);
            chk($sformatf("vec%0d_tag", v), gt, vecs[v].tag);
        end

        do_reset();
        issue_ready = 1;
        for (int j = 0; j < 4; j++) begin
            set_disp(TW'(20 + j), 0, 0, TW'(20 + j), 1, DW'(j), 0);
            tick();
        end
        chk("full_dispatch_ready", dispatch_ready, 0);
        chk("full_occupancy", occupancy, 4);
        set_disp(30, 1, 'h99, 0, 1, 'h98, 0);
        tick();
        tick();
        chk("full_ignored_occupancy", occupancy, 4);
        chk("full_ignored_issue", issue_valid, 0);
        idle();
        set_cdb(1, 22, 'h2222);
        tick();
        idle();
        chk("wake_not_yet_issued", issue_valid, 0);
        chk("wake_still_full", dispatch_ready, 0);
        tick();
        chk("wake_issue_valid", issue_valid, 1);
        chk("wake_issue_tag", issue_tag, 22);
        chk("wake_data_a", data_a, 'h2222);
        chk("wake_dispatch_ready", dispatch_ready, 1);
        chk("wake_occupancy", occupancy, 3);

        do_reset();
        issue_ready = 0;
        for (int j = 1; j <= 3; j++) begin
            set_disp(TW'(j), 1, DW'(32'h100 + j), 0, 1, DW'(32'h200 + j), 0);
            tick();
        end
        idle();
        chk("stall_occupancy", occupancy, 2);
        for (int r = 0; r < 5; r++) begin
            tick();
            chk("stall_valid", issue_valid, 1);
            chk("stall_tag", issue_tag, 1);
            chk("stall_data", {data_a, data_b}, {32'h101, 32'h201});
            chk("stall_occ", occupancy, 2);
        end
        issue_ready = 1;
        tick();
        chk("drain1_tag", issue_tag, 3);
        chk("drain1_data_a", data_a, 'h103);
        chk("drain1_occ", occupancy, 1);
        tick();
        chk("drain2_tag", issue_tag, 2);
        chk("drain2_occ", occupancy, 0);
        tick();
        chk("drain_empty", issue_valid, 0);

        do_reset();
        issue_ready = 1;
        set_disp(7, 1, 'h7, 0, 1, 'h70, 0);
        tick();
        set_disp(8, 1, 'h8, 0, 1, 'h80, 0);
        tick();
        chk("preflush_valid", issue_valid, 1);
        chk("preflush_tag", issue_tag, 7);
        chk("preflush_occ", occupancy, 1);
        set_disp(9, 1, 'h9, 0, 1, 'h90, 0);
        flush = 1;
        tick();
        idle();
        chk("flush_issue_valid", issue_valid, 0);
        chk("flush_occupancy", occupancy, 0);
        for (int r = 0; r < 3; r++) begin
            tick();
            chk("postflush_empty", {issue_valid, occupancy}, 0);
        end

        do_reset();
        issue_ready = 0;
        for (int j = 0; j < 4; j++) begin
            set_disp(TW'(40 + j), 1, DW'(j + 1), 0, 1, DW'(j + 2), 0);
            tick();
        end
        idle();
        chk("premid_occ", occupancy, 3);
        chk("premid_valid", issue_valid, 1);
        #2;
        rst_n = 0;
        #1;
        chk("midrst_valid", issue_valid, 0);
        chk("midrst_occ", occupancy, 0);
        chk("midrst_payload", {issue_tag, data_a, data_b, control_signals}, 0);
        chk("midrst_ready", dispatch_ready, 1);

        do_reset();
        model_clear();
        for (int c = 0; c < 3000; c++) begin
            flush = ($urandom_range(0, 31) == 0);
            dispatch_valid = ($urandom_range(0, 9) < 6);
            disp_control_signals = 11'($urandom);
            disp_branch_sel = 3'($urandom);
            disp_pc = $urandom;
            disp_pc_value_at_prediction = $urandom;
            disp_branch_prediction = 1'($urandom);
            disp_tag = TW'($urandom);
            disp_a_valid = 1'($urandom);
            disp_b_valid = 1'($urandom);
            disp_a_data = $urandom;
            disp_b_data = $urandom;
            disp_a_tag = TW'($urandom_range(0, 15));
            disp_b_tag = TW'($urandom_range(0, 15));
            cdb0_valid = ($urandom_range(0, 9) < 3); cdb0_tag = TW'($urandom_range(0, 15)); cdb0_data = $urandom;
            cdb1_valid = ($urandom_range(0, 9) < 3); cdb1_tag = TW'($urandom_range(0, 15)); cdb1_data = $urandom;
            cdb2_valid = ($urandom_range(0, 9) < 3); cdb2_tag = TW'($urandom_range(0, 15)); cdb2_data = $urandom;
            issue_ready = ($urandom_range(0, 9) < 6);
            @(posedge clk);
            model_step();
            #1;
            occ = 0; frf = 0;
            for (int i = 0; i < DEPTH; i++) begin
                occ += int'(m_v[i]);
                if (!m_v[i]) frf = 1;
            end
            chk("rnd_occupancy", occupancy, 64'(occ));
            chk("rnd_dispatch_ready", dispatch_ready, frf);
            chk("rnd_issue_valid", issue_valid, m_iv);
            if (m_iv) begin
                chk("rnd_tag", issue_tag, m_is.tag);
                chk("rnd_operands", {data_a, data_b}, {m_is.ad, m_is.bd});
                chk("rnd_pcs", {pc, pc_value_at_prediction}, {m_is.pc, m_is.ppc});
                chk("rnd_ctrl", {control_signals, branch_sel, branch_prediction}, {m_is.ctrl, m_is.bsel, m_is.pred});
            end
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
